mul_controller: RTL and testbench

Multi-cycle sequencer for the unsigned multiply unit behind `multu`/`mfhi`/`mflo`. It takes the decoder's multiply-start and move-from-HI/LO requests, runs a radix-2 shift-add multiplication over WIDTH cycles, and owns the architectural HI/LO registers. While a multiply is in flight it raises a stall towards the pipeline for any dependent HI/LO read or any new multiply.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_step.sv | 31 +++
 rtl/mul_controller.sv | 120 ++++++++++++
 tb/tb_mul_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the shift-add multiply
//               sequencer (state encoding, default width, counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Sequencer states: waiting for a multiply, or iterating shift-add steps
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Iteration counter width; needs to hold 0..w-1
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// ============================================================================
// Module      : mul_step
// Description : One radix-2 shift-add iteration. If the multiplier LSB in
//               P[0] is set, the multiplicand is added to the upper half;
//               the (W+1)-bit sum and lower half are then shifted right.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] p_o
);

  logic [WIDTH:0] addend_w;
  logic [WIDTH:0] sum_w;

  // Conditional add into the upper half, keeping the carry so that
  // full-range operands produce an exact 2W-bit product
  always_comb begin
    addend_w = p_i[0] ? {1'b0, m_i} : '0;
    sum_w    = {1'b0, p_i[2*WIDTH-1:WIDTH]} + addend_w;
    p_o      = {sum_w, p_i[WIDTH-1:1]};
  end

endmodule : mul_step
`default_nettype wire

// File: rtl/mul_controller.sv
`default_nettype none
// ============================================================================
// Module      : mul_controller
// Description : Multi-cycle unsigned multiply sequencer owning the HI/LO
//               registers. Accepts a start from IDLE, iterates WIDTH
//               shift-add steps, commits the product to {hi, lo} and
//               pulses done. Stalls dependent HI/LO reads and new starts
//               while a multiply is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_controller
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rdreq,
  input  logic             rdsel,
  output logic [WIDTH-1:0] rddata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] p_step_w;
  logic               last_w;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i (p_q),
    .m_i (m_q),
    .p_o (p_step_w)
  );

  assign last_w = (cnt_q == C_LAST);

  // Next-state logic: accept in IDLE, iterate in RUN, commit on the last step
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = srca;
          p_d     = {{WIDTH{1'b0}}, srcb};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_step_w;
        cnt_d = cnt_q + CW'(1);
        if (last_w) begin
          hi_d    = p_step_w[2*WIDTH-1:WIDTH];
          lo_d    = p_step_w[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Pipeline-facing outputs: no added latency on busy, stall or rddata
  always_comb begin
    busy   = (state_q == RUN);
    stall  = busy & (start | rdreq);
    rddata = rdsel ? hi_q : lo_q;
    hi     = hi_q;
    lo     = lo_q;
    done   = done_q;
  end

endmodule : mul_controller
`default_nettype wire

// File: tb/tb_mul_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_controller
// Description : Directed self-checking bench for mul_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        rdreq;
  logic        rdsel;
  logic [31:0] rddata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_cmp;
  int n_err;

  mul_controller #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .srca   (srca),
    .srcb   (srcb),
    .rdreq  (rdreq),
    .rdsel  (rdsel),
    .rddata (rddata),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one multiply at the current (post-edge) time and wait for busy
  // to drop; returns the number of edges after acceptance and how many
  // done pulses were seen while still busy.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int early_done);
    start = 1'b1;
    srca  = a;
    srcb  = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    early_done = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy === 1'b1 && done === 1'b1) early_done++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi actual=%h required=%h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo actual=%h required=%h", lo, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall actual=%b required=0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done actual=%b required=0", done); end
  endtask

  task automatic test_basic();
    int cyc, ed;
    run_mul(32'd3, 32'd5, cyc, ed);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL basic_latency actual=%0d required=32", cyc); end
    n_cmp++; if (ed != 0) begin n_err++; $display("FAIL basic_early_done actual=%0d required=0", ed); end
    n_cmp++; if (lo !== 32'h0000000F) begin n_err++; $display("FAIL basic_lo actual=%h required=%h", lo, 32'hF); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL basic_hi actual=%h required=%h", hi, 32'h0); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done_pulse actual=%b required=1", done); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_single actual=%b required=0", done); end
  endtask

  task automatic test_carry();
    int cyc, ed;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, cyc, ed);
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL carry_hi actual=%h required=%h", hi, 32'hFFFFFFFE); end
    n_cmp++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL carry_lo actual=%h required=%h", lo, 32'h1); end
    @(posedge clk); #1;
    // Idle read of HI: immediate, no stall
    rdreq = 1'b1; rdsel = 1'b1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_read_stall actual=%b required=0", stall); end
    n_cmp++; if (rddata !== 32'hFFFFFFFE) begin n_err++; $display("FAIL idle_read_hi actual=%h required=%h", rddata, 32'hFFFFFFFE); end
    rdreq = 1'b0; rdsel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_read();
    int n;
    // Start together with a LO read in IDLE: read sees pre-multiply LO
    start = 1'b1; srca = 32'd7; srcb = 32'd6; rdreq = 1'b1; rdsel = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL start_read_stall actual=%b required=0", stall); end
    n_cmp++; if (rddata !== 32'h1) begin n_err++; $display("FAIL start_read_data actual=%h required=%h", rddata, 32'h1); end
    @(posedge clk); #1;
    start = 1'b0; rdreq = 1'b0;
    repeat (5) @(posedge clk);
    #1 rdreq = 1'b1; rdsel = 1'b0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL busy_read_stall actual=%b required=1", stall); end
    n_cmp++; if (rddata !== 32'h1) begin n_err++; $display("FAIL busy_read_old actual=%h required=%h", rddata, 32'h1); end
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n != 27) begin n_err++; $display("FAIL stall_length actual=%0d required=27", n); end
    n_cmp++; if (rddata !== 32'h2A) begin n_err++; $display("FAIL stall_read_data actual=%h required=%h", rddata, 32'h2A); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL stall_read_hi actual=%h required=%h", hi, 32'h0); end
    rdreq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n, cyc, ed;
    start = 1'b1; srca = 32'd4; srcb = 32'd4;
    @(posedge clk); #1;
    // Hold a second start with new operands; must not be sampled while busy
    srca = 32'd2; srcb = 32'd2; #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall actual=%b required=1", stall); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (lo !== 32'd16) begin n_err++; $display("FAIL b2b_first_lo actual=%h required=%h", lo, 32'd16); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_idle_stall actual=%b required=0", stall); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done actual=%b required=1", done); end
    run_mul(32'd2, 32'd2, cyc, ed);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL b2b_second_latency actual=%0d required=32", cyc); end
    n_cmp++; if (lo !== 32'd4) begin n_err++; $display("FAIL b2b_second_lo actual=%h required=%h", lo, 32'd4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, ed, dn;
    run_mul(32'd3, 32'd5, cyc, ed);
    n_cmp++; if (lo !== 32'hF) begin n_err++; $display("FAIL rmid_prior_lo actual=%h required=%h", lo, 32'hF); end
    @(posedge clk); #1;
    start = 1'b1; srca = 32'h1234; srcb = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rmid_hi actual=%h required=%h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rmid_lo actual=%h required=%h", lo, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy actual=%b required=0", busy); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dn != 0) begin n_err++; $display("FAIL rmid_no_done actual=%0d required=0", dn); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rmid_no_commit actual=%h required=%h", lo, 32'h0); end
    run_mul(32'd9, 32'd9, cyc, ed);
    n_cmp++; if (lo !== 32'd81) begin n_err++; $display("FAIL rmid_after_lo actual=%h required=%h", lo, 32'd81); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rmid_after_hi actual=%h required=%h", hi, 32'h0); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    srca  = '0;
    srcb  = '0;
    rdreq = 1'b0;
    rdsel = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_stall_read();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mul_controller
`default_nettype wire
